adc_ltc2308_scan: RTL and testbench

Multi-channel scanning sequencer for the LTC2308 SPI ADC. It supersedes the single-shot per-channel controller.
- Walks a channel mask automatically, in single-scan or continuous mode.
- Handles the device's one-frame config/data pipeline internally.
- Streams tagged samples out and keeps the latest result per channel in a readable register bank.
- Sits between the HAL-facing register interface and the ADC pins.

---
 rtl/adc_ltc2308_scan_if.sv | 13 +
 rtl/adc_ltc2308_scan.sv | 251 +++++++++++++++++++++++++
 tb/tb_adc_ltc2308_scan.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_ltc2308_scan_if.sv
// ADC pin bundle for the LTC2308 scanning sequencer.
//   master : controller side, drives CONVST/SCK/SDI and samples SDO
//   slave  : converter side (or a bench model of it)
`timescale 1ns/1ps
interface adc_ltc2308_scan_if;
    logic ADC_CONVST;
    logic ADC_SCK;
    logic ADC_SDI;
    logic ADC_SDO;

    modport master (output ADC_CONVST, output ADC_SCK, output ADC_SDI, input ADC_SDO);
    modport slave  (input ADC_CONVST, input ADC_SCK, input ADC_SDI, output ADC_SDO);
endinterface

// File: rtl/adc_ltc2308_scan.sv
// Multi-channel scanning sequencer for the LTC2308 SPI ADC.
// Walks ch_mask in ascending order (single scan or continuous), absorbs the
// device's one-frame config->data latency, streams tagged samples and keeps
// the latest result per channel in a combinationally readable bank.
//
// Ports:
//   clk, reset_n        clock (<= 40 MHz), asynchronous active-low reset
//   start               rising edge starts a scan when idle and mask != 0
//   continuous          rescan forever while high (sampled at each scan wrap)
//   ch_mask, uni_mode   channel enables / unipolar select, latched at start
//   busy                accepted start .. end of the closing frame
//   sample_valid/ch/data  one-cycle sample strobe with channel tag and result
//   scan_done           strobes with the last enabled channel's sample
//   rd_addr, rd_data    result bank read port
//   bus                 ADC pins (CONVST, SCK, SDI, SDO)
//
// Optional build macro ADC_AVG_EN: each channel is converted 2^AVG_LOG2 times
// and the truncated mean is reported as its single sample.
`timescale 1ns/1ps
module adc_ltc2308_scan #(
    parameter int DATA_BITS     = 12,
    parameter int CMD_BITS      = 6,
    parameter int CH_NUM        = 8,
    parameter int T_CONVST_HIGH = 1,
    parameter int T_CONV        = 64,
    parameter int T_ACQ         = 320,
    parameter int AVG_LOG2      = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 continuous,
    input  logic [CH_NUM-1:0]    ch_mask,
    input  logic                 uni_mode,
    output logic                 busy,
    output logic                 sample_valid,
    output logic [2:0]           sample_ch,
    output logic [DATA_BITS-1:0] sample_data,
    output logic                 scan_done,
    input  logic [2:0]           rd_addr,
    output logic [DATA_BITS-1:0] rd_data,
    adc_ltc2308_scan_if.master   bus
);
`ifdef ADC_AVG_EN
    localparam int REP_LOG2 = AVG_LOG2;
`else
    localparam int REP_LOG2 = AVG_LOG2 * 0;
`endif
    localparam int REPS  = 1 << REP_LOG2;
    localparam int RW    = (REP_LOG2 > 0) ? REP_LOG2 : 1;
    localparam int ACC_W = DATA_BITS + REP_LOG2;
    localparam int FRAME = T_CONV + DATA_BITS + T_ACQ;
    localparam int TW    = $clog2(FRAME);

    localparam logic [TW-1:0] TK_LAST = TW'(FRAME - 1);
    localparam logic [TW-1:0] TK_CVH  = TW'(T_CONVST_HIGH);
    localparam logic [TW-1:0] TK_SCK0 = TW'(T_CONV);
    localparam logic [TW-1:0] TK_SCKN = TW'(T_CONV + DATA_BITS - 1);
    localparam logic [TW-1:0] TK_SDIN = TW'(T_CONV + CMD_BITS);
    localparam logic [TW-1:0] TK_DONE = TW'(T_CONV + DATA_BITS);
    localparam logic [RW-1:0] REP_LAST = RW'(REPS - 1);

    // Single-ended, sleep off: {S/D=1, O/S=ch[0], S1:S0=ch[2:1], UNI, SLP=0}
    function automatic logic [5:0] cfg_word(input logic [2:0] ch, input logic uni);
        return {1'b1, ch[0], ch[2:1], uni, 1'b0};
    endfunction

    // {wrapped, channel}: next enabled channel after cur, searching upward.
    function automatic logic [3:0] next_en(input logic [CH_NUM-1:0] m, input logic [2:0] cur);
        logic [7:0] m8;
        logic [3:0] r;
        logic       found;
        int         c;
        m8    = 8'(m);
        r     = {1'b1, cur};
        found = 1'b0;
        for (int i = 1; i <= CH_NUM; i++) begin
            c = (int'(cur) + i) % CH_NUM;
            if (!found && m8[c[2:0]]) begin
                found = 1'b1;
                r     = {(c <= int'(cur)), c[2:0]};
            end
        end
        return r;
    endfunction

    function automatic logic [2:0] first_en(input logic [CH_NUM-1:0] m);
        logic [7:0] m8;
        logic [2:0] r;
        m8 = 8'(m);
        r  = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (m8[i]) r = 3'(i);
        end
        return r;
    endfunction

    function automatic logic [DATA_BITS-1:0] avg_trunc(input logic [ACC_W-1:0] s);
        return DATA_BITS'(s >> REP_LOG2);
    endfunction

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                 state_q;
    logic                   start_q, busy_q, convst_q;
    logic                   sample_valid_q, scan_done_q;
    logic [2:0]             sample_ch_q;
    logic [DATA_BITS-1:0]   sample_data_q;
    logic [CH_NUM-1:0]      mask_q;
    logic                   uni_q;
    logic [2:0]             cur_ch_q, prev_ch_q;
    logic [RW-1:0]          rep_q, prev_rep_q;
    logic                   prime_q, closing_q, prev_last_q;
    logic [TW-1:0]          tick_q, tick_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [DATA_BITS-1:0]   bank_q [8];

    logic                   sck_en_q, sdi_q;
    logic [5:0]             cfg_sh_q;
    logic [DATA_BITS-1:0]   sdo_sh_q;

    logic [3:0]             nxt;
    logic [2:0]             first_new;
    logic                   rep_last, scan_wrap, frame_end;

    always_comb begin
        nxt       = next_en(mask_q, cur_ch_q);
        first_new = first_en(ch_mask);
        rep_last  = (rep_q == REP_LAST);
        scan_wrap = rep_last && nxt[3];
        frame_end = (tick_q == TK_LAST);
        tick_d    = frame_end ? '0 : tick_q + 1'b1;
        // First conversion of a channel restarts the running sum.
        acc_d     = ((prev_rep_q == '0) ? '0 : acc_q) + ACC_W'(sdo_sh_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            start_q        <= 1'b0;
            busy_q         <= 1'b0;
            convst_q       <= 1'b0;
            sample_valid_q <= 1'b0;
            scan_done_q    <= 1'b0;
            sample_ch_q    <= '0;
            sample_data_q  <= '0;
            mask_q         <= '0;
            uni_q          <= 1'b0;
            cur_ch_q       <= '0;
            prev_ch_q      <= '0;
            rep_q          <= '0;
            prev_rep_q     <= '0;
            prime_q        <= 1'b0;
            closing_q      <= 1'b0;
            prev_last_q    <= 1'b0;
            tick_q         <= '0;
            acc_q          <= '0;
            for (int i = 0; i < 8; i++) bank_q[i] <= '0;
        end else begin
            start_q        <= start;
            sample_valid_q <= 1'b0;
            scan_done_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && !start_q && (ch_mask != '0)) begin
                        state_q   <= S_RUN;
                        busy_q    <= 1'b1;
                        tick_q    <= '0;
                        convst_q  <= ('0 < TK_CVH);
                        mask_q    <= ch_mask;
                        uni_q     <= uni_mode;
                        cur_ch_q  <= first_new;
                        rep_q     <= '0;
                        prime_q   <= 1'b1;
                        closing_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    tick_q   <= tick_d;
                    convst_q <= !(frame_end && closing_q) && (tick_d < TK_CVH);
                    // Last SDO bit was shifted in on the preceding negedge.
                    if (tick_q == TK_DONE && !prime_q) begin
                        acc_q <= acc_d;
                        if (prev_rep_q == REP_LAST) begin
                            sample_valid_q    <= 1'b1;
                            scan_done_q       <= prev_last_q;
                            sample_ch_q       <= prev_ch_q;
                            sample_data_q     <= avg_trunc(acc_d);
                            bank_q[prev_ch_q] <= avg_trunc(acc_d);
                        end
                    end
                    if (frame_end) begin
                        if (closing_q) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            // Data returned next frame belongs to this frame's config.
                            prime_q     <= 1'b0;
                            prev_ch_q   <= cur_ch_q;
                            prev_rep_q  <= rep_q;
                            prev_last_q <= scan_wrap;
                            if (!rep_last) begin
                                rep_q <= rep_q + 1'b1;
                            end else begin
                                rep_q <= '0;
                                if (nxt[3] && continuous && (ch_mask != '0)) begin
                                    mask_q   <= ch_mask;
                                    cur_ch_q <= first_new;
                                end else begin
                                    cur_ch_q  <= nxt[2:0];
                                    closing_q <= nxt[3];
                                end
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Falling-edge side: SCK enable, SDI shift-out and SDO shift-in all change
    // while clk is low, so the gated SCK cannot glitch.
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_en_q <= 1'b0;
            sdi_q    <= 1'b0;
            cfg_sh_q <= '0;
            sdo_sh_q <= '0;
        end else begin
            sck_en_q <= busy_q && (tick_q >= TK_SCK0) && (tick_q <= TK_SCKN);
            if (sck_en_q) sdo_sh_q <= {sdo_sh_q[DATA_BITS-2:0], bus.ADC_SDO};
            if (busy_q && tick_q == '0) begin
                cfg_sh_q <= cfg_word(cur_ch_q, uni_q);
            end else if (busy_q && (tick_q >= TK_SCK0) && (tick_q < TK_SDIN)) begin
                cfg_sh_q <= {cfg_sh_q[4:0], 1'b0};
            end
            sdi_q <= busy_q && (tick_q >= TK_SCK0) && (tick_q < TK_SDIN) && cfg_sh_q[5];
        end
    end

    assign busy           = busy_q;
    assign sample_valid   = sample_valid_q;
    assign sample_ch      = sample_ch_q;
    assign sample_data    = sample_data_q;
    assign scan_done      = scan_done_q;
    assign rd_data        = bank_q[rd_addr];
    assign bus.ADC_CONVST = convst_q;
    assign bus.ADC_SCK    = clk & sck_en_q;
    assign bus.ADC_SDI    = sdi_q;
endmodule

// File: tb/tb_adc_ltc2308_scan.sv
`timescale 1ns/1ps
module tb_adc_ltc2308_scan;
    localparam int DB    = 12;
    localparam int CB    = 6;
    localparam int TCH   = 1;
    localparam int FRAME = 64 + DB + 320;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic        uni_mode = 1'b0;
    logic [7:0]  ch_mask = 8'h00;
    logic [2:0]  rd_addr = 3'd0;
    logic        busy, sample_valid, scan_done;
    logic [2:0]  sample_ch;
    logic [11:0] sample_data, rd_data;

    adc_ltc2308_scan_if bus ();

    adc_ltc2308_scan dut (
        .clk(clk), .reset_n(reset_n), .start(start), .continuous(continuous),
        .ch_mask(ch_mask), .uni_mode(uni_mode), .busy(busy),
        .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data),
        .scan_done(scan_done), .rd_addr(rd_addr), .rd_data(rd_data), .bus(bus)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [2:0]  ch;
        logic [11:0] d;
        logic        done;
    } exp_t;
    exp_t q[$];

    // ---------------- LTC2308 model ----------------
    logic [11:0] val [8];
    logic [11:0] ofs [4];
    logic [5:0]  cfg_cap = '0;
    logic [5:0]  first_cfg = '0;
    logic [11:0] sdo_w = '0;
    logic [11:0] word;
    logic [2:0]  mch;
    int          sck_cnt = 0;
    int          last_sck = 0;
    int          fc = 0;
    int          fc_base = 0;

    always @(posedge bus.ADC_CONVST or posedge bus.ADC_SCK or negedge bus.ADC_SCK) begin
        if (bus.ADC_CONVST) begin
            // Returns the conversion requested by the previous frame's config.
            mch  = {cfg_cap[3:2], cfg_cap[4]};
            word = val[mch] + ofs[2'((fc - fc_base - 1) & 3)];
            if (fc - fc_base == 1) first_cfg <= cfg_cap;
            last_sck    <= sck_cnt;
            sck_cnt     <= 0;
            fc          <= fc + 1;
            sdo_w       <= word;
            bus.ADC_SDO <= word[11];
        end else if (bus.ADC_SCK) begin
            if (sck_cnt < CB) cfg_cap <= {cfg_cap[4:0], bus.ADC_SDI};
            sck_cnt <= sck_cnt + 1;
        end else begin
            sdo_w       <= sdo_w << 1;
            bus.ADC_SDO <= sdo_w[10];
        end
    end

    // ---------------- monitor ----------------
    int   ncyc = 0;
    int   last_rise = 0;
    int   cst_run = 0;
    int   n_done = 0;
    logic cst_prev = 1'b0;
    logic have_prev = 1'b0;
    exp_t e;

    always @(negedge clk) begin
        ncyc++;
        if (reset_n) begin
            if (bus.ADC_CONVST && !cst_prev) begin
                if (have_prev) begin
                    check("frame_len", ncyc - last_rise, FRAME);
                    check("sck_pulses", last_sck, DB);
                end
                have_prev = 1'b1;
                last_rise = ncyc;
                cst_run   = 0;
            end
            if (bus.ADC_CONVST) cst_run++;
            else if (cst_prev) check("convst_width", cst_run, TCH);
            cst_prev = bus.ADC_CONVST;
            if (sample_valid) begin
                if (q.size() == 0) begin
                    check("extra_sample", {sample_ch, sample_data}, 0);
                end else begin
                    e = q.pop_front();
                    check("smp_ch", sample_ch, e.ch);
                    check("smp_data", sample_data, e.d);
                    check("smp_done", scan_done, e.done);
                end
                if (scan_done) n_done++;
            end else if (scan_done) begin
                check("stray_done", 1, 0);
            end
        end else begin
            cst_prev = 1'b0;
        end
        if (!busy) have_prev = 1'b0;
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_start();
        fc_base = fc;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic run_scan(input int poke, output int bcyc);
        pulse_start();
        bcyc = 0;
        while (busy && bcyc < 20 * FRAME) begin
            bcyc++;
            if (bcyc == poke) begin
                ch_mask = 8'hFF;
                start   = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (busy) check("busy_timeout", 1, 0);
    endtask

    task automatic read_bank(input logic [2:0] a, output logic [11:0] d);
        @(negedge clk);
        rd_addr = a;
        #1 d = rd_data;
    endtask

    task automatic push(input logic [2:0] ch, input logic [11:0] d, input logic done);
        exp_t x;
        x.ch = ch; x.d = d; x.done = done;
        q.push_back(x);
    endtask

    int          bc;
    int          guard;
    logic [11:0] rv;

    initial begin
        for (int i = 0; i < 8; i++) val[i] = 12'(16 * i + 7);
        for (int i = 0; i < 4; i++) ofs[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_done", scan_done, 0);
        check("rst_convst", bus.ADC_CONVST, 0);
        check("rst_sck", bus.ADC_SCK, 0);
        check("rst_sdi", bus.ADC_SDI, 0);
        check("rst_ch", sample_ch, 0);
        check("rst_data", sample_data, 0);
        check("rst_bank", rd_data, 0);
        reset_n = 1'b1;
        @(negedge clk);

`ifdef ADC_AVG_EN
        val[3] = 12'd100;
        ofs[0] = 12'd0; ofs[1] = 12'd1; ofs[2] = 12'd2; ofs[3] = 12'd5;
        ch_mask = 8'h08;
        push(3'd3, 12'd102, 1'b1);
        run_scan(-1, bc);
        check("avg_busy_cycles", bc, 5 * FRAME);
        check("avg_frames", fc - fc_base, 5);
        check("avg_left", q.size(), 0);
        read_bank(3'd3, rv);
        check("avg_bank3", rv, 12'd102);
`else
        // single scan over ch0, ch2
        val[0] = 12'hA5A; val[2] = 12'h123;
        ch_mask = 8'h05;
        push(3'd0, 12'hA5A, 1'b0);
        push(3'd2, 12'h123, 1'b1);
        run_scan(-1, bc);
        check("t1_busy_cycles", bc, 3 * FRAME);
        check("t1_frames", fc - fc_base, 3);
        check("t1_left", q.size(), 0);
        read_bank(3'd0, rv); check("t1_bank0", rv, 12'hA5A);
        read_bank(3'd2, rv); check("t1_bank2", rv, 12'h123);

        // ch7 unipolar config, with a start and mask change while busy
        val[7] = 12'h5F0;
        ch_mask = 8'h80; uni_mode = 1'b1;
        push(3'd7, 12'h5F0, 1'b1);
        run_scan(200, bc);
        check("t2_cfg", first_cfg, 6'b111110);
        check("t2_busy_cycles", bc, 2 * FRAME);
        check("t2_frames", fc - fc_base, 2);
        check("t2_left", q.size(), 0);
        uni_mode = 1'b0;

        // start with an empty mask
        ch_mask = 8'h00;
        pulse_start();
        repeat (50) @(negedge clk);
        check("t3_busy", busy, 0);
        check("t3_frames", fc - fc_base, 0);

        // continuous ch0/ch1, cleared after the third scan_done
        val[0] = 12'h3C1; val[1] = 12'h7E2;
        ch_mask = 8'h03; continuous = 1'b1;
        for (int s = 0; s < 4; s++) begin
            push(3'd0, 12'h3C1, 1'b0);
            push(3'd1, 12'h7E2, 1'b1);
        end
        n_done = 0;
        pulse_start();
        guard = 0;
        while (n_done < 3 && guard < 20 * FRAME) begin
            guard++;
            @(negedge clk);
        end
        check("t4_done3_seen", n_done >= 3, 1);
        continuous = 1'b0;
        guard = 0;
        while (busy && guard < 20 * FRAME) begin
            guard++;
            @(negedge clk);
        end
        check("t4_busy_fell", busy, 0);
        check("t4_scans", n_done, 4);
        check("t4_frames", fc - fc_base, 9);
        check("t4_left", q.size(), 0);
        read_bank(3'd1, rv); check("t4_bank1", rv, 12'h7E2);

        // reset mid-frame, then a fresh full scan
        val[0] = 12'hA5A; val[2] = 12'h123;
        ch_mask = 8'h05;
        pulse_start();
        repeat (FRAME + 70) @(negedge clk);
        check("t5_busy_before", busy, 1);
        reset_n = 1'b0;
        #1;
        check("t5_busy", busy, 0);
        check("t5_convst", bus.ADC_CONVST, 0);
        check("t5_sck", bus.ADC_SCK, 0);
        check("t5_sdi", bus.ADC_SDI, 0);
        check("t5_valid", sample_valid, 0);
        check("t5_ch", sample_ch, 0);
        check("t5_data", sample_data, 0);
        check("t5_bank", rd_data, 0);
        q.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        push(3'd0, 12'hA5A, 1'b0);
        push(3'd2, 12'h123, 1'b1);
        run_scan(-1, bc);
        check("t5_busy_cycles", bc, 3 * FRAME);
        check("t5_frames", fc - fc_base, 3);
        check("t5_left", q.size(), 0);
`endif
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
